// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-stream block: FSM encoding and output buffer geometry.
package fifo_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam int unsigned OBUF_DEPTH = 4;
  localparam int unsigned OBUF_AW    = $clog2(OBUF_DEPTH);

endpackage

// File: rtl/fifo_rd_skid.sv
// Four-entry in-order output buffer carrying {last, data}; pops on valid & ready.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [DSIZE-1:0] data_o,
  output logic             last_o,
  output logic [OBUF_AW:0] occ_o
);

  localparam logic [OBUF_AW-1:0] PtrOne = OBUF_AW'(1);
  localparam logic [OBUF_AW:0]   OccOne = (OBUF_AW + 1)'(1);

  logic [DSIZE:0]     mem_q [OBUF_DEPTH];
  logic [OBUF_AW-1:0] wptr_q, rptr_q;
  logic [OBUF_AW:0]   occ_q, occ_d;
  logic               pop;

  assign valid_o           = (occ_q != '0);
  assign pop               = valid_o & ready_i;
  assign {last_o, data_o}  = mem_q[rptr_q];
  assign occ_o             = occ_q;

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrOne;
      if (pop)    rptr_q <= rptr_q + PtrOne;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= {push_last_i, push_data_i};
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready stream in fixed bursts or on a flush request.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 10,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic             rclk,
  input  logic             rst,
  input  logic             r_empty,
  input  logic [ASIZE-1:0] ruse,
  output logic             r_en,
  input  logic [DSIZE-1:0] rdata,
  input  logic             r_ok,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  localparam logic [ASIZE:0]     LenOne   = (ASIZE + 1)'(1);
  localparam logic [ASIZE:0]     LenBurst = (ASIZE + 1)'(BURST_LEN);
  localparam logic [ASIZE:0]     LenFull  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [OBUF_AW-1:0] PtrOne   = OBUF_AW'(1);
  localparam logic [OBUF_AW:0]   OccLimit = (OBUF_AW + 1)'(OBUF_DEPTH - 1);

  logic [1:0]          state_q, state_d;
  logic [ASIZE:0]      len_q, len_d;
  logic                done_q, done_d;
  logic [OBUF_DEPTH-1:0] tag_q;
  logic [OBUF_AW-1:0]  tag_wptr_q, tag_rptr_q;
  logic [OBUF_AW:0]    occ;
  logic                skid_valid, skid_last, issue_last;

  // One read may be in flight, so reserve a slot for it plus the word landing now.
  assign r_en = ~rst & (state_q != StIdle) & ~r_empty & (len_q != '0) &
                ((occ + (OBUF_AW + 1)'(r_ok)) <= OccLimit);
  assign issue_last = (len_q == LenOne);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (flush) begin
          if (ruse != '0) begin
            state_d = StFlush;
            len_d   = {1'b0, ruse};
          end else if (!r_empty) begin
            state_d = StFlush;  // ruse wrapped: FIFO is full
            len_d   = LenFull;
          end else begin
            done_d  = 1'b1;
          end
        end else if ({1'b0, ruse} >= LenBurst) begin
          state_d = StBurst;
          len_d   = LenBurst;
        end
      end
      StBurst, StFlush: begin
        if (r_en) len_d = len_q - LenOne;
        if (len_d == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      done_q     <= 1'b0;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      done_q  <= done_d;
      if (r_en) tag_wptr_q <= tag_wptr_q + PtrOne;
      if (r_ok) tag_rptr_q <= tag_rptr_q + PtrOne;
    end
  end

  always_ff @(posedge rclk) begin
    if (r_en) tag_q[tag_wptr_q] <= issue_last;
  end

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk_i       (rclk),
    .rst_i       (rst),
    .push_i      (r_ok),
    .push_data_i (rdata),
    .push_last_i (tag_q[tag_rptr_q]),
    .ready_i     (m_ready),
    .valid_o     (skid_valid),
    .data_o      (m_data),
    .last_o      (skid_last),
    .occ_o       (occ)
  );

  assign m_valid = skid_valid & ~rst;
  assign m_last  = skid_last & ~rst;
  assign busy    = ~rst & (state_q != StIdle);
  assign done    = ~rst & done_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream attached to a single-clock behavioural FIFO read port.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rst  = 1'b1;
  logic       r_empty, r_en, r_ok, flush, m_valid, m_ready, m_last, busy, done;
  logic [3:0] ruse;
  logic [7:0] rdata, m_data;

  always #5 rclk = ~rclk;

  // Behavioural FIFO: multi-word writes per edge let the bench reach any fill level at once.
  logic [7:0] mem [16];
  logic [4:0] wptr, rptr;
  int         w_cnt  = 0;
  logic [7:0] w_base = 8'h00;

  always @(posedge rclk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      r_ok <= 1'b0;
    end else begin
      for (int i = 0; i < w_cnt; i++) mem[4'(wptr + 5'(i))] <= w_base + 8'(i);
      wptr  <= wptr + 5'(w_cnt);
      r_ok  <= r_en;
      rdata <= mem[rptr[3:0]];
      if (r_en) rptr <= rptr + 5'd1;
    end
  end

  assign ruse    = 4'(wptr - rptr);
  assign r_empty = (wptr == rptr);

  fifo_rd_stream #(
    .DSIZE     (8),
    .ASIZE     (4),
    .BURST_LEN (4)
  ) dut (
    .rclk    (rclk),
    .rst     (rst),
    .r_empty (r_empty),
    .ruse    (ruse),
    .r_en    (r_en),
    .rdata   (rdata),
    .r_ok    (r_ok),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .done    (done)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         issue_cnt = 0;
  int         done_cnt  = 0;
  int         busy_cnt  = 0;
  logic [8:0] beats [$];

  always @(negedge rclk) begin
    if (!rst) begin
      if (m_valid && m_ready) beats.push_back({m_last, m_data});
      if (r_en) issue_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic smp();
    @(negedge rclk);
  endtask

  task automatic wr(input logic [7:0] base, input int n);
    w_base = base;
    w_cnt  = n;
    cyc();
    w_cnt  = 0;
  endtask

  task automatic clr();
    issue_cnt = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    beats.delete();
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      cyc();
      k++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic chk_beats(input string tag, input logic [7:0] base, input int n);
    logic [8:0] e, g;
    chk({tag, "_count"}, 32'(beats.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = {(i == n - 1), 8'(base + 8'(i))};
      g = (i < beats.size()) ? beats[i] : 9'bx;
      chk({tag, "_beat"}, {23'b0, g}, {23'b0, e});
    end
  endtask

  initial begin
    m_ready = 1'b1;
    flush   = 1'b0;

    // Reset held for two cycles
    cyc();
    cyc();
    smp();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    cyc();
    rst = 1'b0;

    // Threshold: no issue below BURST_LEN, then one 4-word burst
    clr();
    for (int i = 0; i < 4; i++) begin
      wr(8'h10 + 8'(i), 1);
      smp();
      if (i < 3) begin
        chk("thr_r_en_low", 32'(r_en), 32'd0);
        chk("thr_busy_low", 32'(busy), 32'd0);
      end
    end
    cyc();
    smp();
    chk("thr_busy", 32'(busy), 32'd1);
    chk("thr_r_en", 32'(r_en), 32'd1);
    wait_done(20);
    repeat (6) cyc();
    chk("thr_issues", 32'(issue_cnt), 32'd4);
    chk("thr_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("thr_done_pulses", 32'(done_cnt), 32'd1);
    chk_beats("thr", 8'h10, 4);

    // Backpressure: buffer fills to 4, issue stops, then drains at one beat per cycle
    clr();
    m_ready = 1'b0;
    wr(8'h20, 4);
    repeat (12) cyc();
    smp();
    chk("bp_issues", 32'(issue_cnt), 32'd4);
    chk("bp_occ", 32'(dut.occ), 32'd4);
    chk("bp_r_en", 32'(r_en), 32'd0);
    chk("bp_done_pulses", 32'(done_cnt), 32'd1);
    cyc();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_data", 32'(m_data), 32'h20 + 32'(i));
      chk("bp_last", 32'(m_last), 32'(i == 3));
      cyc();
    end
    smp();
    chk("bp_valid_after", 32'(m_valid), 32'd0);
    chk_beats("bp", 8'h20, 4);

    // Flush with two words below threshold
    clr();
    wr(8'h30, 2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    wait_done(20);
    repeat (6) cyc();
    chk("fl2_issues", 32'(issue_cnt), 32'd2);
    chk("fl2_done_pulses", 32'(done_cnt), 32'd1);
    chk_beats("fl2", 8'h30, 2);

    // Flush on an empty FIFO: done next cycle, no reads
    clr();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    smp();
    chk("fl0_done", 32'(done), 32'd1);
    chk("fl0_busy", 32'(busy), 32'd0);
    cyc();
    smp();
    chk("fl0_done_once", 32'(done), 32'd0);
    chk("fl0_issues", 32'(issue_cnt), 32'd0);

    // Full FIFO (ruse wrapped to 0) flushed as 16 words
    clr();
    wr(8'h40, 16);
    smp();
    chk("full_idle", 32'(busy), 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    smp();
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_len", 32'(dut.len_q), 32'd16);
    wait_done(40);
    repeat (6) cyc();
    chk("full_issues", 32'(issue_cnt), 32'd16);
    chk("full_busy_cycles", 32'(busy_cnt), 32'd16);
    chk_beats("full", 8'h40, 16);

    // Flush wins over the burst threshold
    clr();
    wr(8'h50, 5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    smp();
    chk("pri_state", 32'(dut.state_q), 32'd2);
    chk("pri_len", 32'(dut.len_q), 32'd5);
    wait_done(30);
    repeat (6) cyc();
    chk("pri_issues", 32'(issue_cnt), 32'd5);
    chk_beats("pri", 8'h50, 5);

    // Reset in the middle of a burst
    clr();
    m_ready = 1'b0;
    wr(8'h60, 4);
    cyc();
    cyc();
    smp();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    chk("mid_m_valid", 32'(m_valid), 32'd0);
    chk("mid_m_last", 32'(m_last), 32'd0);
    chk("mid_busy_clr", 32'(busy), 32'd0);
    chk("mid_r_en", 32'(r_en), 32'd0);
    chk("mid_occ", 32'(dut.occ), 32'd0);

    // Normal operation resumes after reset
    cyc();
    clr();
    m_ready = 1'b1;
    wr(8'h70, 4);
    wait_done(20);
    repeat (6) cyc();
    chk_beats("post", 8'h70, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DSIZE, default 8, meaning data width; must equal the width of the attached fifo_async.
REQ-002 SHALL have parameter ASIZE, default 10, meaning FIFO address width; must equal the width of the attached fifo_async.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning the read-side fill threshold and burst length; legal range 1..2^ASIZE-1.
REQ-004 SHALL have port rclk  in  1  the single clock, shared with the read domain of fifo_async.
REQ-005 SHALL have port rst  in  1  reset, synchronous to rclk and active-high.
REQ-006 SHALL have port r_empty  in  1  FIFO empty flag.
REQ-007 SHALL have port ruse  in  ASIZE  registered FIFO fill level.
REQ-008 SHALL have port r_en  out  1  FIFO read request; combinational.
REQ-009 SHALL have port rdata  in  DSIZE  FIFO read data.
REQ-010 SHALL have port r_ok  in  1  read data valid; arrives one cycle after r_en.
REQ-011 SHALL have port flush  in  1  drain request; a level, sampled only in IDLE.
REQ-012 SHALL have port m_data  out  DSIZE  stream data.
REQ-013 SHALL have port m_valid  out  1  stream valid.
REQ-014 SHALL have port m_ready  in  1  stream ready.
REQ-015 SHALL have port m_last  out  1  marks the final beat of a burst or flush.
REQ-016 SHALL have port busy  out  1  high when the state is not IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse on return to IDLE.

Function
REQ-018 SHALL implement the states IDLE, BURST and FLUSH.
REQ-019 IDLE transitions: flush=1 -> FLUSH (flush has priority); else ruse>=BURST_LEN -> BURST; else remain in IDLE.
REQ-020 On entering BURST, SHALL latch the remaining count L=BURST_LEN into an (ASIZE+1)-bit counter.
REQ-021 On entering FLUSH, SHALL latch L=ruse. When ruse=0 and r_empty=0 (full FIFO, ruse wrapped), L=2^ASIZE. When ruse=0 and r_empty=1, SHALL return to IDLE next cycle with done=1 and no reads issued.
REQ-022 r_en = (state!=IDLE) & ~r_empty & (L>0) & (occ + r_ok <= 3), where occ is the output-buffer occupancy (0..4).
REQ-023 Each r_en cycle SHALL decrement L. The issue made with L=1 SHALL tag that word last=1; all other issues tag last=0.
REQ-024 After the cycle in which L reaches 0, the next state SHALL be IDLE, with done=1 for exactly that one IDLE cycle.
REQ-025 Each r_ok cycle SHALL push {last tag, rdata} into a 4-entry in-order buffer. Tags SHALL travel with their words via a 4-entry tag FIFO written at issue.
REQ-026 m_valid = (occ>0); m_data and m_last come from the head entry. A pop SHALL occur on m_valid & m_ready.
REQ-027 A simultaneous push and pop SHALL leave occ unchanged. The buffer SHALL never overflow and no word SHALL be dropped or duplicated.
REQ-028 Sustained throughput SHALL be 1 word/cycle with m_ready=1 and the FIFO non-empty.
REQ-029 A new burst MAY start while earlier words are still buffered; output order SHALL be preserved.
REQ-030 m_data is a don't-care while m_valid=0.

Reset
REQ-031 While rst=1, SHALL hold: state=IDLE, L=0, occ=0, buffer pointers=0, m_valid=0, m_last=0, r_en=0, busy=0, done=0.
REQ-032 An r_ok arriving during rst SHALL be ignored. rst SHALL be asserted together with the FIFO reset. A mid-burst reset discards buffered words with no partial m_last.

Structure
REQ-033 Package fifo_pkg SHALL hold the state encoding (IDLE=0, BURST=1, FLUSH=2) and OBUF_DEPTH=4.
REQ-034 The 4-entry data+tag buffer SHALL be sub-module fifo_rd_skid; the FSM and issue logic SHALL live in fifo_rd_stream.

Verification (DSIZE=8, ASIZE=4, BURST_LEN=4, driving a real fifo_async)
REQ-035 Reset: rst=1 for 2 cycles -> m_valid=0, r_en=0, busy=0, done=0.
REQ-036 Threshold: write 0x10..0x13 one word at a time -> r_en=0 while ruse<=3. At ruse=4: busy=1, then 4 r_en cycles, output 0x10..0x13 with m_last on 0x13 only, and a done pulse.
REQ-037 Backpressure: write 4 words with m_ready=0 -> exactly 4 issues, occ=4, r_en=0. Then m_ready=1 -> beats at 1/cycle, no loss.
REQ-038 Flush: ruse=2 with flush=1 -> exactly 2 reads, m_last on the 2nd, done=1. flush with an empty FIFO -> done next cycle, zero reads.
REQ-039 Full wrap: write 16 words (ruse=0, r_empty=0) then flush -> 4 bursts' worth of data (16 reads) in order, m_last on the 16th only.
REQ-040 Priority and reset: flush=1 with ruse=5 -> FLUSH with L=5. rst pulse mid-burst -> IDLE, m_valid=0 on the next cycle.
